// File: rtl/halve_tokens_if.sv
// halve_tokens_if: doubled-token input / recovered-token output bundle
//   master: drives a, stall; observes b, pending, overflow, parity_err
//   slave : the halver side of the same signals
interface halve_tokens_if #(parameter int CNT_W = 8);
  logic a, stall, b, overflow, parity_err;
  logic [CNT_W-1:0] pending;
  modport master(output a, stall, input b, pending, overflow, parity_err);
  modport slave(input a, stall, output b, pending, overflow, parity_err);
endinterface

// File: rtl/halve_tokens.sv
// halve_tokens: turns pairs of consecutive '1's into single pulses, queueing tokens under stall
//   clk, rst       : clock, synchronous active-high reset
//   bus.a          : doubled token stream
//   bus.stall      : 1 = do not emit this cycle
//   bus.b          : one-cycle pulse per recovered token
//   bus.pending    : completed tokens not yet emitted
//   bus.overflow   : sticky, queue exceeded MAX_PENDING
//   bus.parity_err : sticky, run of '1's ended odd (only with HALVE_TOKENS_STRICT_PARITY_EN)
module halve_tokens #(
  parameter int MAX_PENDING = 200,
  localparam int CNT_W = $clog2(MAX_PENDING + 2)
) (
  input logic clk,
  input logic rst,
  halve_tokens_if.slave bus
);
  logic half_q, half_d, b_q, b_d, ovf_q, ovf_d, complete, emit, sat;
  logic [CNT_W-1:0] pend_q, pend_d, avail;
  // CNT_W holds MAX_PENDING+1, so avail never wraps
  always_comb begin
    complete = bus.a & half_q;
    avail = pend_q + CNT_W'(complete);
    emit = !bus.stall && avail != '0;
    sat = !emit && avail > CNT_W'(MAX_PENDING);
    half_d = bus.a & ~half_q;
    b_d = emit;
    pend_d = emit ? avail - CNT_W'(1) : sat ? CNT_W'(MAX_PENDING) : avail;
    ovf_d = ovf_q | sat;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      half_q <= 1'b0;
      b_q <= 1'b0;
      pend_q <= '0;
      ovf_q <= 1'b0;
    end else begin
      half_q <= half_d;
      b_q <= b_d;
      pend_q <= pend_d;
      ovf_q <= ovf_d;
    end
  end
  assign bus.b = b_q;
  assign bus.pending = pend_q;
  assign bus.overflow = ovf_q;
`ifdef HALVE_TOKENS_STRICT_PARITY_EN
  logic perr_q;
  always_ff @(posedge clk) perr_q <= rst ? 1'b0 : perr_q | (~bus.a & half_q);
  assign bus.parity_err = perr_q;
`else
  assign bus.parity_err = 1'b0;
`endif
endmodule
